mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-stage consumer of the EX/MEM pipeline register in the forwarding pipeline. It decodes the 9-bit to-memory control bundle, performs data-memory stores and word/halfword loads on an internal RAM, and drives the MEM-stage forwarding tap. It also registers the write-back bundle into the MEM/WB register and latches the halt condition that stops the machine.

## Interface
Parameters:
- ADDR_W, 10, word-address width of the data RAM (2**ADDR_W 32-bit words)
- CNT_W, 16, width of the memory-access counter

Ports. Reset rst, synchronous, active-high; clock clk.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- result_in  in  32  ALU result from EX/MEM; memory byte address for loads and stores
- rb_v_in  in  32  store data from EX/MEM
- to_mem_sig_in  in  9  bit8 rw_en, bit7 lh, bit6 memread, bit5 memw, bits4:0 rW
- hault_in  in  1  halt marker travelling with the instruction
- fwd_en  out  1  combinational; MEM-stage value is a valid forward
- fwd_rw  out  5  combinational; destination register of the MEM-stage instruction
- fwd_data  out  32  combinational; MEM-stage write-back value
- wb_en  out  1  registered MEM/WB register-write enable
- wb_rw  out  5  registered destination register
- wb_data  out  32  registered write-back value
- hault_out  out  1  registered sticky halt
- mem_cnt  out  CNT_W  number of committed loads plus stores

## Operation
- Word address = result_in[ADDR_W+1:2]. Bits above ADDR_W+1 are ignored. result_in[1:0] is ignored for word accesses.
- Load value is read combinationally from the RAM.
  - lh=0: the full word.
  - lh=1: halfword = word[31:16] if result_in[1]=1, else word[15:0]; sign-extended to 32 bits.
- MEM value = memread ? load value : result_in.
- eff_en = rw_en & (rW != 0). Writes to r0 are never forwarded or written back.
- fwd_en = eff_en & !halted, fwd_rw = rW, fwd_data = MEM value, all combinational in the same cycle.
- Store: memw=1 and !halted → RAM[word addr] <= rb_v_in at the rising edge. Always a full word, independent of lh.
- memread=1 and memw=1 together: the load returns the old RAM content (read before write), and the store still commits.
- halted flag: set at the edge where hault_in=1 and !halted. It stays set until rst.
  - The halting instruction itself commits normally: its store, its write-back, and its count.
  - Once halted, stores are suppressed, the MEM/WB register holds its value, and mem_cnt holds.
- mem_cnt increments by 1 at each edge where (memread|memw) & !halted. It wraps modulo 2**CNT_W.
- RAM contents are not cleared by rst.

## Timing
- Reset values: wb_en=0, wb_rw=0, wb_data=0, hault_out=0, mem_cnt=0, halted=0. The same values apply at time 0 via initial values.
- rst has priority over every other event, including a hault_in or memw in the same cycle. No store commits on a reset edge.
- Latency:
  - Forwarding outputs: 0 cycles (combinational).
  - wb_*: 1 cycle after the instruction is presented.
  - Store becomes visible to a load presented in the next cycle.
  - hault_out rises 1 cycle after hault_in is sampled.
- No handshake. One instruction is accepted per clock. Bubbles are all-zero control (to_mem_sig_in=0).
- Reset mid-stream: the next non-reset cycle behaves as the first instruction after power-up. Previously stored RAM data is preserved.

## Structure
- The shared pipeline package holds:
  - Control-bundle bit-position constants: RW_EN=8, LH=7, MEMREAD=6, MEMW=5, RW_MSB=4, RW_LSB=0.
  - The 9-bit bundle width.
  - The zero-register index.
- Sub-module dmem_ram: synchronous write, asynchronous read, parameter ADDR_W. It is separated so that an FPGA block-RAM version can be swapped in.
- Load-extract logic, forwarding, MEM/WB register, halt latch, and counter live in the top level.

## Test plan
- Store 0xDEADBEEF to address 0x10, then a word load to r5 from 0x10 → fwd_data=0xDEADBEEF in the load cycle; next cycle wb_en=1, wb_rw=5, wb_data=0xDEADBEEF; mem_cnt=2.
- After that store, lh from 0x12 → 0xFFFFDEAD; lh from 0x10 → 0xFFFFBEEF. Store 0x00007FFF, then lh from the same word address → 0x00007FFF.
- ALU-only instruction (result_in=0x1234, rw_en=1, rW=7, memread=0) → fwd_en=1, fwd_data=0x1234. With rW=0 → fwd_en=0, and next cycle wb_en=0.
- Instruction with hault_in=1 and a store of 0x55 to address 0x20, followed by a store of 0x66 to 0x20 → hault_out=1 one cycle later; RAM[0x20]=0x55; wb_* frozen; mem_cnt frozen at 1.
- rst asserted for 1 cycle while halted and while memw=1 → all outputs return to their reset values, the store does not commit, and a following load from 0x20 returns 0x55.
- memread and memw both set to the same address holding 0xA → load returns 0xA; a subsequent load returns the new data.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_wb_stage_pkg: to-memory control bundle layout and decoder. Rev 1.0 |
// +--------------------------------------------------------------------+
package mem_wb_stage_pkg;

  localparam int BUNDLE_W = 9;
  localparam int REG_W    = 5;

  localparam int RW_EN   = 8;
  localparam int LH      = 7;
  localparam int MEMREAD = 6;
  localparam int MEMW    = 5;
  localparam int RW_MSB  = 4;
  localparam int RW_LSB  = 0;

  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic             rw_en;
    logic             lh;
    logic             memread;
    logic             memw;
    logic [REG_W-1:0] rw;
  } mem_ctl_t;

  function automatic mem_ctl_t decode_ctl(input logic [BUNDLE_W-1:0] sig);
    mem_ctl_t c;
    c.rw_en   = sig[RW_EN];
    c.lh      = sig[LH];
    c.memread = sig[MEMREAD];
    c.memw    = sig[MEMW];
    c.rw      = sig[RW_MSB:RW_LSB];
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_wb_stage_if: EX/MEM inputs, forwarding tap and MEM/WB outputs. Rev 1.0 |
// +--------------------------------------------------------------------+
interface mem_wb_stage_if #(
  parameter int CNT_W = 16
);
  import mem_wb_stage_pkg::*;

  logic [31:0]          result_in;
  logic [31:0]          rb_v_in;
  logic [BUNDLE_W-1:0]  to_mem_sig_in;
  logic                 hault_in;
  logic                 fwd_en;
  logic [REG_W-1:0]     fwd_rw;
  logic [31:0]          fwd_data;
  logic                 wb_en;
  logic [REG_W-1:0]     wb_rw;
  logic [31:0]          wb_data;
  logic                 hault_out;
  logic [CNT_W-1:0]     mem_cnt;

  modport master (
    output result_in, rb_v_in, to_mem_sig_in, hault_in,
    input  fwd_en, fwd_rw, fwd_data, wb_en, wb_rw, wb_data, hault_out, mem_cnt
  );

  modport slave (
    input  result_in, rb_v_in, to_mem_sig_in, hault_in,
    output fwd_en, fwd_rw, fwd_data, wb_en, wb_rw, wb_data, hault_out, mem_cnt
  );

endinterface
`default_nettype wire

// File: rtl/mem_wb_stage_dmem_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_ram: word RAM, synchronous write, asynchronous read. Rev 1.0  |
// +--------------------------------------------------------------------+
module dmem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  // Contents deliberately have no reset so data survives a pipeline reset.
  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_wb_stage: MEM stage - loads/stores, forwarding tap, MEM/WB reg, halt. Rev 1.0 |
// +--------------------------------------------------------------------+
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  mem_wb_stage_if.slave  bus
);

  mem_ctl_t          ctl;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       ram_rdata;
  logic [15:0]       half;
  logic [31:0]       load_val;
  logic [31:0]       mem_val;
  logic              eff_en;
  logic              ram_we;
  logic              unused_addr_bits;

  logic              wb_en_q     = 1'b0;
  logic [REG_W-1:0]  wb_rw_q     = '0;
  logic [31:0]       wb_data_q   = '0;
  logic              halted_q    = 1'b0;
  logic [CNT_W-1:0]  mem_cnt_q   = '0;

  logic              wb_en_d;
  logic [REG_W-1:0]  wb_rw_d;
  logic [31:0]       wb_data_d;
  logic              halted_d;
  logic [CNT_W-1:0]  mem_cnt_d;

  assign ctl              = decode_ctl(bus.to_mem_sig_in);
  assign word_addr        = bus.result_in[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.result_in[31:ADDR_W+2], bus.result_in[0]};

  // Reset wins over a same-cycle store; a halted machine never writes.
  assign ram_we = ctl.memw & ~halted_q & ~rst;

  dmem_ram #(
    .ADDR_W (ADDR_W)
  ) u_dmem_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (word_addr),
    .wdata_i (bus.rb_v_in),
    .rdata_o (ram_rdata)
  );

  assign half     = bus.result_in[1] ? ram_rdata[31:16] : ram_rdata[15:0];
  assign load_val = ctl.lh ? {{16{half[15]}}, half} : ram_rdata;
  assign mem_val  = ctl.memread ? load_val : bus.result_in;
  assign eff_en   = ctl.rw_en & (ctl.rw != ZERO_REG);

  assign bus.fwd_en   = eff_en & ~halted_q;
  assign bus.fwd_rw   = ctl.rw;
  assign bus.fwd_data = mem_val;

  // The halting instruction itself still commits; everything freezes after.
  always_comb begin
    wb_en_d   = wb_en_q;
    wb_rw_d   = wb_rw_q;
    wb_data_d = wb_data_q;
    halted_d  = halted_q;
    mem_cnt_d = mem_cnt_q;
    if (!halted_q) begin
      wb_en_d   = eff_en;
      wb_rw_d   = ctl.rw;
      wb_data_d = mem_val;
      if (ctl.memread | ctl.memw) begin
        mem_cnt_d = mem_cnt_q + CNT_W'(1);
      end
      if (bus.hault_in) begin
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      wb_rw_q   <= '0;
      wb_data_q <= '0;
      halted_q  <= 1'b0;
      mem_cnt_q <= '0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_rw_q   <= wb_rw_d;
      wb_data_q <= wb_data_d;
      halted_q  <= halted_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

  assign bus.wb_en     = wb_en_q;
  assign bus.wb_rw     = wb_rw_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.hault_out = halted_q;
  assign bus.mem_cnt   = mem_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_wb_stage: directed vectors with a cycle-tagged scoreboard. Rev 1.0 |
// +--------------------------------------------------------------------+
module tb_mem_wb_stage;

  logic clk;
  logic rst;
  int   cyc = 0;

  mem_wb_stage_if #(.CNT_W(16)) bus ();

  mem_wb_stage #(
    .ADDR_W (10),
    .CNT_W  (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          tag;
    bit          is_reg;
    int          idx;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   n          = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] C(input bit rwen, input bit lh, input bit rd,
                                   input bit wr, input logic [4:0] rw);
    return {rwen, lh, rd, wr, rw};
  endfunction

  // Drive one instruction; the forward tap is due this cycle, MEM/WB state next.
  task automatic vec(input logic r, input logic [31:0] res, input logic [31:0] rbv,
                     input logic [8:0] ctl, input logic h,
                     input logic fe, input logic [4:0] frw, input logic [31:0] fd,
                     input logic we, input logic [4:0] wrw, input logic [31:0] wd,
                     input logic ho, input logic [15:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    bus.result_in     = res;
    bus.rb_v_in       = rbv;
    bus.to_mem_sig_in = ctl;
    bus.hault_in      = h;
    e.tag = cyc;     e.is_reg = 1'b0; e.idx = n; e.exp = {26'b0, fe, frw, fd};
    q.push_back(e);
    e.tag = cyc + 1; e.is_reg = 1'b1; e.idx = n; e.exp = {9'b0, we, wrw, wd, ho, cnt};
    q.push_back(e);
    n++;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [63:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].tag <= cyc) begin
        e = q.pop_front();
        if (e.is_reg)
          act = {9'b0, bus.wb_en, bus.wb_rw, bus.wb_data, bus.hault_out, bus.mem_cnt};
        else
          act = {26'b0, bus.fwd_en, bus.fwd_rw, bus.fwd_data};
        compared++;
        if (e.tag != cyc || act !== e.exp) begin
          mismatched++;
          $display("FAIL %s[%0d] cycle %0d: got %h expected %h",
                   e.is_reg ? "wb" : "fwd", e.idx, cyc, act, e.exp);
        end
      end
    end
  end

  initial begin : driver
    rst               = 1'b1;
    bus.result_in     = '0;
    bus.rb_v_in       = '0;
    bus.to_mem_sig_in = '0;
    bus.hault_in      = 1'b0;

    vec(1, 32'h0,    32'h0,        C(0,0,0,0,0),  0, 0,0,32'h0,        0,0,32'h0,        0,16'd0);
    vec(1, 32'h0,    32'h0,        C(0,0,0,0,0),  0, 0,0,32'h0,        0,0,32'h0,        0,16'd0);
    vec(0, 32'h10,   32'hDEADBEEF, C(0,0,0,1,0),  0, 0,0,32'h10,       0,0,32'h10,       0,16'd1);
    vec(0, 32'h10,   32'h0,        C(1,0,1,0,5),  0, 1,5,32'hDEADBEEF, 1,5,32'hDEADBEEF, 0,16'd2);
    vec(0, 32'h12,   32'h0,        C(1,1,1,0,6),  0, 1,6,32'hFFFFDEAD, 1,6,32'hFFFFDEAD, 0,16'd3);
    vec(0, 32'h10,   32'h0,        C(1,1,1,0,7),  0, 1,7,32'hFFFFBEEF, 1,7,32'hFFFFBEEF, 0,16'd4);
    vec(0, 32'h40,   32'h00007FFF, C(0,0,0,1,0),  0, 0,0,32'h40,       0,0,32'h40,       0,16'd5);
    vec(0, 32'h40,   32'h0,        C(1,1,1,0,8),  0, 1,8,32'h00007FFF, 1,8,32'h00007FFF, 0,16'd6);
    vec(0, 32'h42,   32'h0,        C(1,1,1,0,9),  0, 1,9,32'h0,        1,9,32'h0,        0,16'd7);
    vec(0, 32'h1234, 32'h0,        C(1,0,0,0,7),  0, 1,7,32'h1234,     1,7,32'h1234,     0,16'd7);
    vec(0, 32'h5678, 32'h0,        C(1,0,0,0,0),  0, 0,0,32'h5678,     0,0,32'h5678,     0,16'd7);
    vec(0, 32'h80,   32'hA,        C(0,0,0,1,0),  0, 0,0,32'h80,       0,0,32'h80,       0,16'd8);
    vec(0, 32'h80,   32'hB,        C(1,0,1,1,10), 0, 1,10,32'hA,       1,10,32'hA,       0,16'd9);
    vec(0, 32'h80,   32'h0,        C(1,0,1,0,11), 0, 1,11,32'hB,       1,11,32'hB,       0,16'd10);
    vec(1, 32'h0,    32'h0,        C(0,0,0,0,0),  0, 0,0,32'h0,        0,0,32'h0,        0,16'd0);
    vec(0, 32'h20,   32'h55,       C(0,0,0,1,0),  1, 0,0,32'h20,       0,0,32'h20,       1,16'd1);
    vec(0, 32'h20,   32'h66,       C(1,0,0,1,3),  0, 0,3,32'h20,       0,0,32'h20,       1,16'd1);
    vec(0, 32'h20,   32'h0,        C(1,0,1,0,4),  0, 0,4,32'h55,       0,0,32'h20,       1,16'd1);
    vec(1, 32'h20,   32'h77,       C(0,0,0,1,0),  1, 0,0,32'h20,       0,0,32'h0,        0,16'd0);
    vec(0, 32'h20,   32'h0,        C(1,0,1,0,4),  0, 1,4,32'h55,       1,4,32'h55,       0,16'd1);
    vec(0, 32'h0,    32'h0,        C(0,0,0,0,0),  0, 0,0,32'h0,        0,0,32'h0,        0,16'd1);
    vec(0, 32'h1010, 32'h0,        C(1,0,1,0,12), 0, 1,12,32'hDEADBEEF,1,12,32'hDEADBEEF,0,16'd2);

    repeat (3) @(negedge clk);
    #1;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
